tta_rf_wr_arbiter: RTL and testbench
====================================

# tta_rf_wr_arbiter

Round-robin write-port arbiter placed in front of a single-write-port TTA register file (e.g. the 1-write/1-read boolean guard RF). Several transport buses may target the RF write socket in the same instruction. The arbiter captures all such moves, serialises them onto the RF's t1 port one per cycle, and raises a lock request to the global-lock network until the backlog drains. Guard and read paths of the RF are untouched.

## Interface
- NREQ, 4, number of transport buses able to write the RF (2..8)
- DATA_W, 1, RF data width (1 for boolean RF)
- OPC_W, 1, RF index/opcode width (log2 of RF depth)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- io_glock  in  1  global lock from core; 1 freezes issue and capture
- io_req_valid  in  NREQ  per-bus write move targeting this RF
- io_req_opcode  in  NREQ*OPC_W  per-bus RF index, bus i at [i*OPC_W +: OPC_W]
- io_req_data  in  NREQ*DATA_W  per-bus write data, same packing
- io_t1load  out  1  RF write strobe
- io_t1opcode  out  OPC_W  RF write index
- io_t1data  out  DATA_W  RF write data
- io_lock_req  out  1  stall request into global-lock OR tree
- io_waw  out  1  one-cycle pulse: accepted batch contained ≥2 writes to same index
- io_err  out  1  sticky: request presented while not acceptable

## Operation
- State per bus i: pend_v[i], pend_opc[i], pend_dat[i]; round-robin pointer rr (0..NREQ-1); P = popcount(pend_v).
- Accept condition: acc = !io_glock && !io_lock_req. When acc, pend_v[i] |= io_req_valid[i], opcode/data latched for those i.
- Issue (combinational from pending regs): if P>0 and !io_glock, pick first set pend_v starting at rr, wrapping; drive io_t1load=1, io_t1opcode/io_t1data from that slot; on the edge clear pend_v[g], rr <= (g+1) mod NREQ.
- Same-cycle issue and accept: clearing of issued slot and setting of new valids both apply; new valid for slot g wins (slot re-filled).
- io_lock_req = (P >= 2). With P<=1 the single pending write issues this cycle, so the core may present the next instruction.
- io_glock=1: no issue, no capture, io_t1load=0, pending, rr unchanged.
- io_req_valid≠0 while !acc: requests ignored, io_err set until reset.
- WAW: two accepted bits with equal opcode -> io_waw pulses the cycle after accept; writes still issued in rr order (last issued value persists).
- io_t1opcode/io_t1data = 0 when io_t1load=0.

## Timing
- Reset values: all pend_v=0, rr=0, io_t1load=0, io_t1opcode=0, io_t1data=0, io_lock_req=0, io_waw=0, io_err=0.
- Latency: request accepted at edge k -> first write on t1 in cycle k+1 (absent io_glock).
- Batch of n simultaneous requests: writes in cycles k+1..k+n; io_lock_req high cycles k+1..k+n-1.
- Each cycle of io_glock=1 extends the above by one cycle.
- Reset mid-drain discards pending writes; no t1 strobe in the cycle after reset deasserts unless new requests were accepted.

## Structure
- Package tta_rf_arb_pkg: NREQ/width defaults, packed-slice helper functions, rr increment function.
- Sub-module tta_rr_pick: NREQ-bit request vector + rr pointer -> one-hot grant + index + any; purely combinational, reused by other TTA arbiters.
- Top holds pending registers, rr, WAW/err flags.

## Test plan
- Single write bus 2, opcode 1, data 1 -> cycle+1 t1load=1, t1opcode=1, t1data=1; io_lock_req stays 0.
- All 4 buses valid, opcodes 0,1,0,1, rr=0 -> writes from buses 0,1,2,3 in cycles +1..+4; io_lock_req high +1..+3; io_waw pulse at +1; rr=0 after.
- Batch of 3 with io_glock high in cycle +2 -> writes at +1,+3,+4; lock_req high +1..+3; nothing on t1 at +2.
- Request while io_lock_req=1 -> ignored, io_err=1 and stays 1 until reset.
- Back-to-back single requests on bus 1 every cycle -> one write per cycle, latency 1, no lock_req.
- reset asserted during 4-deep drain -> outputs 0 asynchronously; after release no stray t1load.

Source files
------------

// File: rtl/tta_rf_arb_pkg.sv
// Shared defaults and small helpers for the TTA register-file write arbiters.
// Slice helpers work on a zero-extended bus so one function serves every width.
package tta_rf_arb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int DATA_W_DEF = 1;
    localparam int OPC_W_DEF  = 1;

    localparam int BUS_MAX   = 256;
    localparam int SLICE_MAX = 32;

    // Field idx of width w from a packed bus whose fields are laid out LSB-first.
    function automatic logic [SLICE_MAX-1:0] get_slice(input logic [BUS_MAX-1:0] vec,
                                                       input int unsigned idx,
                                                       input int unsigned w);
        logic [BUS_MAX-1:0]   sh;
        logic [SLICE_MAX-1:0] mask;
        sh   = vec >> (idx * w);
        mask = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
        return sh[SLICE_MAX-1:0] & mask;
    endfunction

    function automatic int unsigned rr_inc(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/tta_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr, wrapping.
// Produces one-hot grant, binary index and an any-request flag.
module tta_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned p;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        p   = 0;
        for (int off = 0; off < N; off++) begin
            p = (32'(rr) + 32'(off)) % 32'(N);
            if (!any && req[p[IW-1:0]]) begin
                any             = 1'b1;
                gnt[p[IW-1:0]]  = 1'b1;
                idx             = p[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/tta_rf_wr_arbiter.sv
// Serialises simultaneous write moves onto a single RF write port, one per
// cycle in round-robin order, holding the core via io_lock_req while a backlog exists.
module tta_rf_wr_arbiter
    import tta_rf_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_glock,
    input  logic [NREQ-1:0]          io_req_valid,
    input  logic [NREQ*OPC_W-1:0]    io_req_opcode,
    input  logic [NREQ*DATA_W-1:0]   io_req_data,
    output logic                     io_t1load,
    output logic [OPC_W-1:0]         io_t1opcode,
    output logic [DATA_W-1:0]        io_t1data,
    output logic                     io_lock_req,
    output logic                     io_waw,
    output logic                     io_err
);

    localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   pend_v_reg, pend_v_next;
    logic [OPC_W-1:0]  pend_opc_reg [NREQ];
    logic [DATA_W-1:0] pend_dat_reg [NREQ];
    logic [RR_W-1:0]   rr_reg, rr_next;
    logic              waw_reg, waw_next;
    logic              err_reg, err_next;

    logic [OPC_W-1:0]  req_opc [NREQ];
    logic [DATA_W-1:0] req_dat [NREQ];

    logic [NREQ-1:0]   pick_gnt;
    logic [RR_W-1:0]   pick_idx;
    logic              pick_any;
    logic              issue;
    logic              acc;
    logic              dup;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_opc[gi] = OPC_W'(get_slice(BUS_MAX'(io_req_opcode), gi, OPC_W));
        assign req_dat[gi] = DATA_W'(get_slice(BUS_MAX'(io_req_data), gi, DATA_W));
    end

    tta_rr_pick #(.N(NREQ)) u_pick (
        .req (pend_v_reg),
        .rr  (rr_reg),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Two or more pending bits: clearing the lowest set bit leaves something.
    assign io_lock_req = |(pend_v_reg & (pend_v_reg - NREQ'(1)));
    assign acc         = !io_glock && !io_lock_req;
    assign issue       = pick_any && !io_glock;
    assign io_waw      = waw_reg;
    assign io_err      = err_reg;

    always_comb begin
        io_t1load   = issue;
        io_t1opcode = '0;
        io_t1data   = '0;
        if (issue) begin
            io_t1opcode = pend_opc_reg[pick_idx];
            io_t1data   = pend_dat_reg[pick_idx];
        end
    end

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = i + 1; j < NREQ; j++) begin
                if (io_req_valid[i] && io_req_valid[j] && req_opc[i] == req_opc[j]) begin
                    dup = 1'b1;
                end
            end
        end
    end

    // A new request on the slot being issued re-fills it, so set wins over clear.
    always_comb begin
        pend_v_next = pend_v_reg & ~(issue ? pick_gnt : '0);
        if (acc) begin
            pend_v_next = pend_v_next | io_req_valid;
        end
        rr_next  = issue ? RR_W'(rr_inc(32'(pick_idx), NREQ)) : rr_reg;
        waw_next = acc && dup;
        err_next = err_reg || ((|io_req_valid) && !acc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_v_reg <= '0;
            rr_reg     <= '0;
            waw_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            pend_v_reg <= pend_v_next;
            rr_reg     <= rr_next;
            waw_reg    <= waw_next;
            err_reg    <= err_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                pend_opc_reg[i] <= '0;
                pend_dat_reg[i] <= '0;
            end
        end else if (acc) begin
            for (int i = 0; i < NREQ; i++) begin
                if (io_req_valid[i]) begin
                    pend_opc_reg[i] <= req_opc[i];
                    pend_dat_reg[i] <= req_dat[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_tta_rf_wr_arbiter.sv
// Bench for tta_rf_wr_arbiter: directed scenarios plus random traffic, every
// cycle checked against a slot/queue-level reference model of the arbiter.
module tb_tta_rf_wr_arbiter;

    localparam int N  = 4;
    localparam int OW = 2;
    localparam int DW = 4;
    localparam int VW = 1 + OW + DW + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_glock;
    logic [N-1:0]      io_req_valid;
    logic [N*OW-1:0]   io_req_opcode;
    logic [N*DW-1:0]   io_req_data;
    logic              io_t1load;
    logic [OW-1:0]     io_t1opcode;
    logic [DW-1:0]     io_t1data;
    logic              io_lock_req;
    logic              io_waw;
    logic              io_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: which buses still owe a write, their values, next bus to favour.
    bit mv [N];
    int mo [N];
    int md [N];
    int mrr;
    bit mwaw;
    bit merr;
    bit e_load;
    bit e_lock;
    int e_opc;
    int e_dat;
    int e_g;

    always #5 clk = ~clk;

    tta_rf_wr_arbiter #(.NREQ(N), .DATA_W(DW), .OPC_W(OW)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_glock      (io_glock),
        .io_req_valid  (io_req_valid),
        .io_req_opcode (io_req_opcode),
        .io_req_data   (io_req_data),
        .io_t1load     (io_t1load),
        .io_t1opcode   (io_t1opcode),
        .io_t1data     (io_t1data),
        .io_lock_req   (io_lock_req),
        .io_waw        (io_waw),
        .io_err        (io_err)
    );

    function automatic logic [VW-1:0] obs_vec();
        return {io_t1load, io_t1opcode, io_t1data, io_lock_req, io_waw, io_err};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_load, OW'(e_opc), DW'(e_dat), e_lock, mwaw, merr};
    endfunction

    function automatic int model_pending();
        int p = 0;
        for (int i = 0; i < N; i++) p += mv[i] ? 1 : 0;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mo[i] = 0; md[i] = 0;
        end
        mrr = 0; mwaw = 1'b0; merr = 1'b0;
    endtask

    function automatic void model_outputs();
        int p;
        p      = model_pending();
        e_lock = (p >= 2);
        e_load = (p > 0) && !io_glock;
        e_g    = -1;
        e_opc  = 0;
        e_dat  = 0;
        if (e_load) begin
            for (int k = 0; k < N; k++) begin
                if (e_g < 0 && mv[(mrr + k) % N]) e_g = (mrr + k) % N;
            end
            e_opc = mo[e_g];
            e_dat = md[e_g];
        end
    endfunction

    // Drive one instruction's inputs, then evaluate the model mid-cycle.
    task automatic apply(input logic [N-1:0] v, input logic [N*OW-1:0] o,
                         input logic [N*DW-1:0] d, input logic g);
        io_req_valid  = v;
        io_req_opcode = o;
        io_req_data   = d;
        io_glock      = g;
        @(negedge clk);
        model_outputs();
    endtask

    task automatic advance();
        bit acc;
        bit dup;
        @(posedge clk);
        cyc++;
        acc = !io_glock && !e_lock;
        dup = 1'b0;
        if (e_load) begin
            mv[e_g] = 1'b0;
            mrr = (e_g + 1) % N;
        end
        if (acc) begin
            for (int i = 0; i < N; i++) begin
                if (io_req_valid[i]) begin
                    mv[i] = 1'b1;
                    mo[i] = int'(io_req_opcode[i*OW +: OW]);
                    md[i] = int'(io_req_data[i*DW +: DW]);
                    for (int j = 0; j < i; j++) begin
                        if (io_req_valid[j] && io_req_opcode[j*OW +: OW] == io_req_opcode[i*OW +: OW])
                            dup = 1'b1;
                    end
                end
            end
        end
        mwaw = acc && dup;
        merr = merr || ((io_req_valid != '0) && !acc);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL reset_state got=%h exp=0", obs_vec());
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        apply(N'(4'b0100), (N*OW)'(1) << (2*OW), (N*DW)'(1) << (2*DW), 1'b0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL single_accept cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            apply('0, '0, '0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                total++;
                if (io_t1load !== 1'b1 || io_t1opcode !== OW'(1) || io_t1data !== DW'(1) || io_lock_req !== 1'b0) begin
                    bad++; $display("FAIL single_plus1 got=%b/%h/%h/%b exp=1/1/1/0",
                                    io_t1load, io_t1opcode, io_t1data, io_lock_req);
                end
            end
            advance();
        end
    endtask

    task automatic test_batch4();
        logic [N*DW-1:0] d;
        // A lone write on bus 3 brings the pointer round to bus 0 first.
        apply(N'(4'b1000), '0, '0, 1'b0);
        advance();
        apply('0, '0, '0, 1'b0);
        advance();
        d = (N*DW)'({$urandom, $urandom});
        apply('1, {2'd1, 2'd0, 2'd1, 2'd0}, d, 1'b0);
        advance();
        for (int c = 1; c <= 6; c++) begin
            apply('0, '0, '0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL batch4 cyc=+%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 1) begin
                total++;
                if (io_waw !== 1'b1 || io_t1data !== d[DW-1:0] || io_lock_req !== 1'b1) begin
                    bad++; $display("FAIL batch4_first got=waw%b dat%h lock%b exp=waw1 dat%h lock1",
                                    io_waw, io_t1data, io_lock_req, d[DW-1:0]);
                end
            end
            advance();
        end
    endtask

    task automatic test_glock();
        apply(N'(4'b1011), N*OW'($urandom), (N*DW)'($urandom), 1'b0);
        advance();
        for (int c = 1; c <= 5; c++) begin
            apply('0, '0, '0, c == 2);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL glock cyc=+%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            if (c == 2) begin
                total++;
                if (io_t1load !== 1'b0 || io_lock_req !== 1'b1) begin
                    bad++; $display("FAIL glock_hold got=load%b lock%b exp=load0 lock1", io_t1load, io_lock_req);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            apply(N'(4'b0010), (N*OW)'($urandom), (N*DW)'($urandom), 1'b0);
            total++;
            if (obs_vec() !== exp_vec() || (c > 0 && io_t1load !== 1'b1) || io_lock_req !== 1'b0) begin
                bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic           g;
        logic [N-1:0]   v;
        for (int c = 0; c < 300; c++) begin
            g = ($urandom_range(0, 4) == 0);
            v = (!g && model_pending() < 2) ? N'($urandom) : '0;
            apply(v, (N*OW)'($urandom), (N*DW)'($urandom), g);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            apply('0, '0, '0, 1'b0);
            advance();
        end
    endtask

    task automatic test_err();
        apply(N'(4'b0101), (N*OW)'($urandom), (N*DW)'($urandom), 1'b0);
        advance();
        apply(N'(4'b0010), (N*OW)'($urandom), (N*DW)'($urandom), 1'b0);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL err_reject cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        advance();
        for (int c = 0; c < 4; c++) begin
            apply('0, '0, '0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec() || io_err !== 1'b1) begin
                bad++; $display("FAIL err_sticky cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_drain();
        apply('1, (N*OW)'($urandom), (N*DW)'($urandom), 1'b0);
        advance();
        io_req_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++; $display("FAIL reset_async got=%h exp=0", obs_vec());
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            apply('0, '0, '0, 1'b0);
            total++;
            if (obs_vec() !== exp_vec() || io_t1load !== 1'b0) begin
                bad++; $display("FAIL reset_no_stray cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        reset         = 1'b1;
        io_glock      = 1'b0;
        io_req_valid  = '0;
        io_req_opcode = '0;
        io_req_data   = '0;
        model_reset();
        test_reset();
        test_single();
        test_batch4();
        test_glock();
        test_back_to_back();
        test_random();
        test_err();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
